// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: rebuilds parallel words from an MSB-first serial stream.
// A shift register assembles the current frame while a separate output register
// holds the last completed word until it is consumed through a valid/ready
// handshake. Words that complete while the output is still occupied are dropped
// and flagged as overrun. Frames cut short by a drop of ser_en are flagged as abort.
module serial_frame_receiver #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ser_en,
  input  logic             ser_in,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun,
  output logic             abort,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             drop;

  // Assembled word and completion/drop decisions for the current cycle
  always_comb begin
    word = {shift_q[WIDTH-2:0], ser_in};
    done = (state == RECV) && ser_en && (bit_cnt == CW'(WIDTH - 1));
    drop = done && valid && !ready;
  end

  // Frame FSM plus output register, handshake and status flags
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      abort <= 1'b0;

      case (state)
        IDLE: begin
          if (ser_en) begin
            // Start from a clean register so stale bits never leak into a word.
            shift_q <= {{(WIDTH-1){1'b0}}, ser_in};
            bit_cnt <= CW'(1);
            state   <= RECV;
          end
        end
        RECV: begin
          if (!ser_en) begin
            abort   <= 1'b1;
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (done) begin
            // IDLE samples the very next bit, so consecutive frames need no gap.
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            shift_q <= word;
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase

      if (done) begin
        if (!valid || ready) begin
          data_out <= word;
          valid    <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      // Clear first so that a simultaneous drop still leaves the flag set.
      if (clr_ovr) overrun <= 1'b0;
      if (drop)    overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Testbench for serial_frame_receiver: directed scenarios plus randomized traffic,
// compared against a bit-queue reference model of the receiver.
module tb_serial_frame_receiver;

  localparam int W  = 16;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          res;
  logic          ser_en;
  logic          ser_in;
  logic          ready;
  logic          clr_ovr;
  logic [W-1:0]  data_out;
  logic          valid;
  logic          overrun;
  logic          abort;
  logic [CW-1:0] bit_cnt;

  int vectors = 0;
  int errors  = 0;

  serial_frame_receiver #(.WIDTH(W)) dut (
    .clk     (clk),
    .res     (res),
    .ser_en  (ser_en),
    .ser_in  (ser_in),
    .ready   (ready),
    .clr_ovr (clr_ovr),
    .data_out(data_out),
    .valid   (valid),
    .overrun (overrun),
    .abort   (abort),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: collected bits live in a queue; a word is the first W bits.
  logic         mq[$];
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovr;
  logic         m_abort;

  always @(posedge clk or posedge res) begin : model
    logic         got_word;
    logic [W-1:0] w;
    if (res) begin
      mq.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_abort = 1'b0;
    end else begin
      got_word = 1'b0;
      w        = '0;
      m_abort  = 1'b0;
      if (ser_en) begin
        mq.push_back(ser_in);
        if (mq.size() == W) begin
          for (int i = 0; i < W; i++) w[W-1-i] = mq[i];
          mq.delete();
          got_word = 1'b1;
        end
      end else if (mq.size() != 0) begin
        m_abort = 1'b1;
        mq.delete();
      end
      if (got_word && m_valid && !ready) begin
        m_ovr = 1'b1;
      end else begin
        if (clr_ovr) m_ovr = 1'b0;
        if (m_valid && ready) m_valid = 1'b0;
        if (got_word) begin
          m_data  = w;
          m_valid = 1'b1;
        end
      end
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic tick(input logic en, input logic b, input logic rdy, input logic clr);
    ser_en  = en;
    ser_in  = b;
    ready   = rdy;
    clr_ovr = clr;
    @(posedge clk);
    #1;
  endtask

  // Shift one word MSB first; ready for the last bit may differ from the rest.
  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) tick(1'b1, w[i], (i == 0) ? rdy_last : rdy, 1'b0);
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0);
  endtask

  task automatic test_reset;
    // Some activity first so that reset clears real state.
    send_word(16'h5A5A, 1'b0, 1'b0);
    send_word(16'h0F0F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    res = 1'b1;
    #2;
    vectors++;
    if ({data_out, valid, overrun, abort, bit_cnt} !== {W'(0), 3'b000, CW'(0)}) begin
      errors++;
      $display("FAIL reset_clear: got data=%h v=%b ovr=%b ab=%b cnt=%0d, want all zero",
               data_out, valid, overrun, abort, bit_cnt);
    end
    #2;
    res = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({valid, abort, bit_cnt} !== {2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL reset_after: got v=%b ab=%b cnt=%0d, want 0 0 0", valid, abort, bit_cnt);
    end
  endtask

  task automatic test_single_frame;
    for (int i = W - 1; i >= 0; i--) begin
      tick(1'b1, 1'(16'hA5C3 >> i), 1'b1, 1'b0);
      if (i == 8) begin
        vectors++;
        if (bit_cnt !== CW'(8)) begin
          errors++;
          $display("FAIL single_bitcnt: got %0d want 8", bit_cnt);
        end
      end
    end
    vectors++;
    if (valid !== 1'b1 || data_out !== 16'hA5C3 || bit_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL single_word: got v=%b data=%h cnt=%0d want v=1 data=a5c3 cnt=0",
               valid, data_out, bit_cnt);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (valid !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: got v=%b ab=%b want v=0 ab=0", valid, abort);
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 7; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    vectors++;
    if (bit_cnt !== CW'(7)) begin
      errors++;
      $display("FAIL abort_cnt: got %0d want 7", bit_cnt);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (abort !== 1'b1 || valid !== 1'b0 || bit_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL abort_pulse: got ab=%b v=%b cnt=%0d want 1 0 0", abort, valid, bit_cnt);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_width: got ab=%b want 0", abort);
    end
    send_word(16'h1234, 1'b0, 1'b0);
    vectors++;
    if (valid !== 1'b1 || data_out !== 16'h1234) begin
      errors++;
      $display("FAIL abort_next: got v=%b data=%h want v=1 data=1234", valid, data_out);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    send_word(16'h00FF, 1'b0, 1'b0);
    vectors++;
    if (valid !== 1'b1 || data_out !== 16'h00FF || overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got v=%b data=%h ovr=%b want 1 00ff 0", valid, data_out, overrun);
    end
    send_word(16'hFF00, 1'b0, 1'b0);
    vectors++;
    if (valid !== 1'b1 || data_out !== 16'h00FF || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun: got v=%b data=%h ovr=%b want 1 00ff 1", valid, data_out, overrun);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky: got ovr=%b want 1", overrun);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (overrun !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_clear: got ovr=%b v=%b want 0 1", overrun, valid);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (valid !== 1'b0 || data_out !== 16'h00FF) begin
      errors++;
      $display("FAIL bp_transfer: got v=%b data=%h want 0 00ff", valid, data_out);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: got v=%b want 0", valid);
    end
  endtask

  task automatic test_collision;
    logic [W-1:0] first;
    first = W'($urandom);
    send_word(first, 1'b0, 1'b0);
    send_word(16'hBEEF, 1'b0, 1'b1);
    vectors++;
    if (valid !== 1'b1 || data_out !== 16'hBEEF || overrun !== 1'b0) begin
      errors++;
      $display("FAIL collide: got v=%b data=%h ovr=%b want 1 beef 0", valid, data_out, overrun);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    res = 1'b1;
    #2;
    vectors++;
    if ({data_out, valid, overrun, abort, bit_cnt} !== {W'(0), 3'b000, CW'(0)}) begin
      errors++;
      $display("FAIL midreset_clear: got data=%h v=%b ovr=%b ab=%b cnt=%0d want all zero",
               data_out, valid, overrun, abort, bit_cnt);
    end
    #2;
    res = 1'b0;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (abort !== 1'b0) begin
      errors++;
      $display("FAIL midreset_noabort: got ab=%b want 0", abort);
    end
    send_word(16'h8001, 1'b1, 1'b1);
    vectors++;
    if (valid !== 1'b1 || data_out !== 16'h8001) begin
      errors++;
      $display("FAIL midreset_next: got v=%b data=%h want 1 8001", valid, data_out);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] w;
    for (int k = 0; k < 4; k++) begin
      w = W'($urandom);
      send_word(w, 1'b1, 1'b1);
      vectors++;
      if (valid !== 1'b1 || data_out !== w || bit_cnt !== CW'(0)) begin
        errors++;
        $display("FAIL b2b_word%0d: got v=%b data=%h cnt=%0d want 1 %h 0",
                 k, valid, data_out, bit_cnt, w);
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      vectors++;
      if (data_out !== m_data || valid !== m_valid || overrun !== m_ovr ||
          abort !== m_abort || bit_cnt !== CW'(mq.size())) begin
        errors++;
        $display("FAIL random_cyc%0d: got data=%h v=%b ovr=%b ab=%b cnt=%0d want data=%h v=%b ovr=%b ab=%b cnt=%0d",
                 i, data_out, valid, overrun, abort, bit_cnt,
                 m_data, m_valid, m_ovr, m_abort, mq.size());
      end
    end
  endtask

  initial begin
    res     = 1'b1;
    ser_en  = 1'b0;
    ser_in  = 1'b0;
    ready   = 1'b0;
    clr_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    idle_cycles(2, 1'b1);

    test_reset();
    test_single_frame();
    test_abort();
    test_backpressure();
    test_collision();
    test_reset_midframe();
    test_back_to_back();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
